// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with a maskable, level-type interrupt.
// Register map (word offsets): 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved.
// CTRL[0] En, CTRL[2:1] Mode (01 auto-reload, anything else one-shot), CTRL[3] IM.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_load = 2'd1,
    st_cnt  = 2'd2,
    st_int  = 2'd3
  } state_t;

  localparam logic [1:0] off_ctrl   = 2'd0;
  localparam logic [1:0] off_preset = 2'd1;
  localparam logic [1:0] off_count  = 2'd2;
  localparam logic [1:0] mode_auto  = 2'b01;

  state_t      state, state_nx;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_nx;
  logic        irq_pend;

  // FSM side effects, merged with bus writes in the register process
  logic        pend_set, pend_clr, en_clr;

  logic        wr_ctrl, wr_preset;
  logic        en, auto_mode;

  assign wr_ctrl   = we && (addr == off_ctrl);
  assign wr_preset = we && (addr == off_preset);
  assign en        = ctrl[0];
  assign auto_mode = (ctrl[2:1] == mode_auto);

  // State register; a reset at any point aborts counting without an irq
  always_ff @(posedge clk) begin
    if (!reset) state <= st_idle;
    else        state <= state_nx;
  end

  // Next-state and count update; decisions use the registered ctrl value
  always_comb begin
    state_nx = state;
    count_nx = count;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    en_clr   = 1'b0;
    unique case (state)
      st_idle: begin
        if (en) state_nx = st_load;
      end
      st_load: begin
        count_nx = preset;
        state_nx = st_cnt;
      end
      st_cnt: begin
        if (!en) begin
          // count freezes; re-enable restarts from LOAD
          state_nx = st_idle;
        end else if (count > 32'd1) begin
          count_nx = count - 32'd1;
        end else begin
          // 0 and 1 both terminate, so PRESET=0 acts like PRESET=1
          count_nx = 32'd0;
          pend_set = 1'b1;
          state_nx = st_int;
        end
      end
      st_int: begin
        if (auto_mode) begin
          pend_clr = 1'b1;
          state_nx = st_load;
        end else begin
          en_clr   = 1'b1;
          state_nx = st_idle;
        end
      end
      default: state_nx = st_idle;
    endcase
  end

  // Programmer-visible registers; a bus write to CTRL beats FSM updates
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_pend <= 1'b0;
    end else begin
      count <= count_nx;
      if (wr_ctrl)     ctrl    <= din[3:0];
      else if (en_clr) ctrl[0] <= 1'b0;
      if (wr_preset)   preset  <= din;
      if (wr_ctrl)       irq_pend <= 1'b0;
      else if (pend_set) irq_pend <= 1'b1;
      else if (pend_clr) irq_pend <= 1'b0;
    end
  end

  // Zero-latency read mux
  always_comb begin
    dout = 32'd0;
    unique case (addr)
      off_ctrl:   dout = {28'd0, ctrl};
      off_preset: dout = preset;
      off_count:  dout = count;
      default:    dout = 32'd0;
    endcase
  end

  // IM gates the output only; the pending flag is tracked regardless
  assign irq = ctrl[3] & irq_pend;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: rule-level reference model, every-cycle comparison of
// irq and all four read offsets, directed scenarios plus random traffic.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  always #5 clk = ~clk;

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  int tests = 0;
  int fails = 0;

  // reference model: phase 0 idle, 1 load, 2 counting, 3 interrupt
  logic [3:0]  m_ctrl    = 4'd0;
  logic [31:0] m_preset  = 32'd0;
  logic [31:0] m_count   = 32'd0;
  bit          m_pend    = 1'b0;
  int          m_phase   = 0;

  logic [31:0] rd [4];
  logic        irq_s;

  function automatic logic [31:0] m_read(int a);
    case (a)
      0:       return {28'd0, m_ctrl};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one edge of the timer's rules, applied to the values held before the edge
  task automatic model_step(bit r, bit w, logic [1:0] a, logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_cnt;
    bit          n_pend;
    int          n_ph;
    if (!r) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_phase = 0;
      return;
    end
    n_ctrl = m_ctrl; n_cnt = m_count; n_pend = m_pend; n_ph = m_phase;
    case (m_phase)
      0: if (m_ctrl[0]) n_ph = 1;
      1: begin n_cnt = m_preset; n_ph = 2; end
      2: begin
        if (!m_ctrl[0]) n_ph = 0;
        else if (m_count > 1) n_cnt = m_count - 1;
        else begin n_cnt = 0; n_pend = 1'b1; n_ph = 3; end
      end
      default: begin
        if (m_ctrl[2:1] == 2'b01) begin n_ph = 1; n_pend = 1'b0; end
        else begin n_ctrl[0] = 1'b0; n_ph = 0; end
      end
    endcase
    if (w && a == 2'd0) begin n_ctrl = d[3:0]; n_pend = 1'b0; end
    if (w && a == 2'd1) m_preset = d;
    m_ctrl = n_ctrl; m_count = n_cnt; m_pend = n_pend; m_phase = n_ph;
  endtask

  // compare irq and every read offset against the model
  task automatic sample();
    irq_s = irq;
    check("irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pend});
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      rd[a] = dout;
      check($sformatf("dout[%0d]", a), dout, m_read(a));
    end
  endtask

  task automatic cyc(bit r, bit w, logic [1:0] a, logic [31:0] d);
    reset = r; we = w; addr = a; din = d;
    @(posedge clk);
    model_step(r, w, a, d);
    @(negedge clk);
    we = 1'b0;
    sample();
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b1, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  int first;
  bit found;
  logic [31:0] exp_cnt [1:11] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
                                  32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

  initial begin
    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;

    // reset state
    cyc(1'b0, 1'b0, 2'd0, 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 32'd0);
    for (int a = 0; a < 4; a++) check($sformatf("rst_rd%0d", a), rd[a], 32'd0);
    check("rst_irq", {31'd0, irq_s}, 32'd0);
    idle(1);

    // one-shot, PRESET=5: irq 7 edges after the CTRL write, then En drops
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (irq_s && first == 0) first = k;
    end
    check("oneshot_edge", first, 32'd7);
    check("oneshot_ctrl", rd[0], 32'h8);
    check("oneshot_count", rd[2], 32'd0);
    check("oneshot_hold", {31'd0, irq_s}, 32'd1);
    wr(2'd0, 32'h8);
    check("oneshot_clr", {31'd0, irq_s}, 32'd0);

    // auto-reload, PRESET=3: period 5, COUNT 3,2,1,0,0,...
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 11; k++) begin
      idle(1);
      check($sformatf("auto_cnt%0d", k), rd[2], exp_cnt[k]);
      check($sformatf("auto_irq%0d", k), {31'd0, irq_s}, {31'd0, (k == 5 || k == 10)});
    end
    wr(2'd0, 32'h0);
    idle(3);

    // masked: pend sets but irq stays low; a CTRL write clears pend
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      check("mask_irq", {31'd0, irq_s}, 32'd0);
    end
    wr(2'd0, 32'h9);
    check("mask_wr_clr", {31'd0, irq_s}, 32'd0);
    wr(2'd0, 32'h0);
    idle(3);

    // disable mid-count, then re-enable reloads PRESET
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      idle(1);
      if (rd[2] == 32'd60) found = 1'b1;
    end
    check("reach60", {31'd0, found}, 32'd1);
    wr(2'd0, 32'h0);
    idle(3);
    check("freeze", {31'd0, (rd[2] == 32'd59 || rd[2] == 32'd60)}, 32'd1);
    wr(2'd0, 32'h1);
    idle(2);
    check("reload100", rd[2], 32'd100);

    // writes to COUNT and reserved offset are ignored
    wr(2'd2, 32'h1234);
    wr(2'd3, 32'h1234);
    check("rsvd_rd", rd[3], 32'd0);
    check("preset_kept", rd[1], 32'd100);

    // reset mid-count
    idle(5);
    cyc(1'b0, 1'b0, 2'd0, 32'd0);
    for (int a = 0; a < 4; a++) check($sformatf("midrst_rd%0d", a), rd[a], 32'd0);
    check("midrst_irq", {31'd0, irq_s}, 32'd0);
    idle(4);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, w;
      logic [1:0] a;
      logic [31:0] d;
      r = ($urandom_range(0, 299) != 0);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd1)      d = $urandom_range(0, 7);
      else                d = $urandom;
      cyc(r, w, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
